// File: rtl/fnd_scan_ctrl.sv
// Scan controller for a 4-digit FND. It multiplexes the digits with leading-zero
// suppression and per-digit blink, and can show a timed message with a busy handshake.
module fnd_scan_ctrl #(
   parameter int SCAN_DIV    = 100_000,
   parameter int BLINK_SLOTS = 250
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [19:0] digits_i,
   input  logic        blank_lz,
   input  logic [3:0]  blink_mask,
   input  logic        msg_load,
   input  logic [19:0] msg_code,
   input  logic [7:0]  msg_frames,
   output logic        msg_busy,
   output logic [3:0]  an,
   output logic [4:0]  bcd,
   output logic        frame_tick
);

   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int BW = (BLINK_SLOTS > 1) ? $clog2(BLINK_SLOTS) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
   localparam logic [BW-1:0] BLK_MAX = BW'(BLINK_SLOTS - 1);

   typedef enum logic {NORM, MSG} state_t;

   state_t        state_q;
   logic [CW-1:0] cnt_q;
   logic [1:0]    sel_q;
   logic [BW-1:0] bcnt_q;
   logic          blink_q;
   logic [19:0]   mreg_q;
   logic [7:0]    fcnt_q;
   logic          busy_q;
   logic [3:0]    an_q;
   logic [4:0]    bcd_q;
   logic          ft_q;

   logic          slot_tick, frame_edge, msg_exit, show_msg, blank_d;
   logic [1:0]    nsel;
   logic [4:0]    code_d, bcd_d;
   logic [3:0]    an_d;

   function automatic logic [4:0] field(input logic [19:0] v, input logic [1:0] k);
      logic [4:0] f;
      case (k)
         2'd0:    f = v[4:0];
         2'd1:    f = v[9:5];
         2'd2:    f = v[14:10];
         default: f = v[19:15];
      endcase
      return f;
   endfunction

   // A digit is a leading zero only if it and every more significant digit are 5'h00.
   function automatic logic lz_blank(input logic [19:0] v, input logic [1:0] k);
      logic [3:0] z;
      logic       b;
      z = {v[19:15] == 5'd0, v[14:10] == 5'd0, v[9:5] == 5'd0, v[4:0] == 5'd0};
      case (k)
         2'd1:    b = &z[3:1];
         2'd2:    b = &z[3:2];
         2'd3:    b = z[3];
         default: b = 1'b0;
      endcase
      return b;
   endfunction

   always_comb begin
      slot_tick  = (cnt_q == CNT_MAX);
      nsel       = sel_q + 2'd1;
      frame_edge = slot_tick && (sel_q == 2'd3);
      msg_exit   = (state_q == MSG) && frame_edge && (fcnt_q == 8'd1);
      // The slot registered on the exit edge already belongs to normal mode.
      show_msg   = (state_q == MSG) && !msg_exit;
      code_d     = field(show_msg ? mreg_q : digits_i, nsel);
      blank_d    = !show_msg && ((blank_lz && lz_blank(digits_i, nsel)) ||
                                 (blink_q && blink_mask[nsel]));
      an_d       = blank_d ? 4'hf : ~(4'b0001 << nsel);
      bcd_d      = blank_d ? 5'h0f : code_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= NORM;
         cnt_q   <= '0;
         sel_q   <= 2'd3;
         bcnt_q  <= '0;
         blink_q <= 1'b0;
         mreg_q  <= '0;
         fcnt_q  <= '0;
         busy_q  <= 1'b0;
         an_q    <= 4'hf;
         bcd_q   <= 5'h0f;
         ft_q    <= 1'b0;
      end else begin
         cnt_q <= slot_tick ? '0 : cnt_q + 1'b1;
         ft_q  <= frame_edge;
         if (slot_tick) begin
            sel_q <= nsel;
            an_q  <= an_d;
            bcd_q <= bcd_d;
            if (bcnt_q == BLK_MAX) begin
               bcnt_q  <= '0;
               blink_q <= ~blink_q;
            end else begin
               bcnt_q <= bcnt_q + 1'b1;
            end
         end
         case (state_q)
            NORM: begin
               if (msg_load && (msg_frames != 8'd0)) begin
                  state_q <= MSG;
                  mreg_q  <= msg_code;
                  fcnt_q  <= msg_frames;
                  busy_q  <= 1'b1;
               end
            end
            MSG: begin
               if (frame_edge) begin
                  fcnt_q <= fcnt_q - 8'd1;
                  if (fcnt_q == 8'd1) begin
                     state_q <= NORM;
                     busy_q  <= 1'b0;
                  end
               end
            end
            default: state_q <= NORM;
         endcase
      end
   end

   assign msg_busy   = busy_q;
   assign an         = an_q;
   assign bcd        = bcd_q;
   assign frame_tick = ft_q;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Bench for fnd_scan_ctrl: first-frame vector table, hand-written message/reset
// sequences, and random traffic checked every cycle against a slot-count model.
module tb_fnd_scan_ctrl;

   localparam int SD = 4;
   localparam int BS = 2;

   logic        clk;
   logic        reset;
   logic [19:0] digits_i;
   logic        blank_lz;
   logic [3:0]  blink_mask;
   logic        msg_load;
   logic [19:0] msg_code;
   logic [7:0]  msg_frames;
   logic        msg_busy;
   logic [3:0]  an;
   logic [4:0]  bcd;
   logic        frame_tick;

   int tests = 0;
   int fails = 0;

   fnd_scan_ctrl #(.SCAN_DIV(SD), .BLINK_SLOTS(BS)) dut (
      .clk(clk), .reset(reset), .digits_i(digits_i), .blank_lz(blank_lz),
      .blink_mask(blink_mask), .msg_load(msg_load), .msg_code(msg_code),
      .msg_frames(msg_frames), .msg_busy(msg_busy), .an(an), .bcd(bcd),
      .frame_tick(frame_tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model state: k = clock edges since reset release; the n-th slot tick lands on
   // edge n*SD, shows digit (n-1)%4, and uses blink phase ((n-1)/BS)%2.
   int          k;
   bit          m_act;
   int          m_left;
   logic [19:0] m_reg;
   logic [3:0]  e_an;
   logic [4:0]  e_bcd;
   logic        e_ft, e_busy;

   function automatic logic [4:0] fld(input logic [19:0] v, input int d);
      return v[d*5 +: 5];
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_edge();
      int  n, d;
      bit  tick, wrap, lz, bl;
      if (reset) begin
         k = 0; m_act = 0; m_left = 0;
         e_an = 4'hf; e_bcd = 5'h0f; e_ft = 1'b0; e_busy = 1'b0;
         return;
      end
      k++;
      tick = (k % SD) == 0;
      n    = k / SD;
      d    = (n - 1) % 4;
      wrap = tick && (d == 0);
      e_ft = wrap;
      if (tick) begin
         if (m_act && !(wrap && m_left == 1)) begin
            e_an  = ~(4'b0001 << d);
            e_bcd = fld(m_reg, d);
         end else begin
            lz = blank_lz && (d != 0);
            for (int j = d; j < 4; j++)
               if (fld(digits_i, j) != 5'd0) lz = 0;
            bl = ((((n - 1) / BS) % 2) == 1) && blink_mask[d];
            if (lz || bl) begin
               e_an = 4'hf; e_bcd = 5'h0f;
            end else begin
               e_an = ~(4'b0001 << d); e_bcd = fld(digits_i, d);
            end
         end
      end
      if (m_act) begin
         if (wrap) begin
            m_left--;
            if (m_left == 0) m_act = 0;
         end
      end else if (msg_load && msg_frames != 8'd0) begin
         m_act = 1; m_left = int'(msg_frames); m_reg = msg_code;
      end
      e_busy = m_act;
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      chk("mdl_an", {28'd0, an}, {28'd0, e_an});
      chk("mdl_bcd", {27'd0, bcd}, {27'd0, e_bcd});
      chk("mdl_frame_tick", {31'd0, frame_tick}, {31'd0, e_ft});
      chk("mdl_msg_busy", {31'd0, msg_busy}, {31'd0, e_busy});
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   typedef struct {
      logic [19:0] dig;
      logic        blz;
      logic [3:0]  mask;
      logic [15:0] an_all;   // {slot digit3, digit2, digit1, digit0}
      logic [19:0] bcd_all;
   } vec_t;

   vec_t tbl[6];

   initial begin
      int guard, nft;
      reset = 1'b0; digits_i = '0; blank_lz = 1'b0; blink_mask = '0;
      msg_load = 1'b0; msg_code = '0; msg_frames = '0;

      // First frame after reset: digit0,1 use blink phase 0, digit2,3 phase 1.
      tbl[0] = '{20'h20C41, 1'b0, 4'b0000, 16'h7BDE, {5'd4, 5'd3, 5'd2, 5'd1}};
      tbl[1] = '{{5'd0, 5'd0, 5'd7, 5'd0}, 1'b1, 4'b0000, 16'hFFDE, {5'h0f, 5'h0f, 5'd7, 5'd0}};
      tbl[2] = '{20'h00000, 1'b1, 4'b0000, 16'hFFFE, {5'h0f, 5'h0f, 5'h0f, 5'd0}};
      tbl[3] = '{20'h20C41, 1'b0, 4'b1111, 16'hFFDE, {5'h0f, 5'h0f, 5'd2, 5'd1}};
      tbl[4] = '{{5'h1f, 5'h10, 5'h0f, 5'h15}, 1'b1, 4'b0000, 16'h7BDE, {5'h1f, 5'h10, 5'h0f, 5'h15}};
      tbl[5] = '{{5'd0, 5'd5, 5'd0, 5'd0}, 1'b1, 4'b0000, 16'hFBDE, {5'h0f, 5'd5, 5'd0, 5'd0}};

      for (int i = 0; i < 6; i++) begin
         do_reset();
         chk("rst_an", {28'd0, an}, 32'hf);
         chk("rst_bcd", {27'd0, bcd}, 32'h0f);
         digits_i = tbl[i].dig; blank_lz = tbl[i].blz; blink_mask = tbl[i].mask;
         for (int j = 0; j < 4; j++) begin
            repeat (SD) step();
            chk("tbl_an", {28'd0, an}, {28'd0, tbl[i].an_all[j*4 +: 4]});
            chk("tbl_bcd", {27'd0, bcd}, {27'd0, tbl[i].bcd_all[j*5 +: 5]});
            chk("tbl_frame_tick", {31'd0, frame_tick}, (j == 0) ? 32'd1 : 32'd0);
         end
      end

      // Blink over several frames on digit1 and on all digits.
      do_reset();
      digits_i = 20'h20C41; blank_lz = 1'b0; blink_mask = 4'b0010;
      repeat (12 * SD) step();
      blink_mask = 4'b1111;
      repeat (12 * SD) step();
      blink_mask = 4'b0000;

      // Message loaded mid-frame; further loads held high through the exit edge.
      do_reset();
      repeat (6) step();
      msg_load = 1'b1; msg_code = {5'h10, 5'h11, 5'h11, 5'h0f}; msg_frames = 8'd2;
      step();
      chk("msg_busy_set", {31'd0, msg_busy}, 32'd1);
      msg_code = 20'hABCDE; msg_frames = 8'd3;
      guard = 0; nft = 0;
      do begin
         step();
         nft += int'(frame_tick);
         guard++;
      end while (e_busy && guard < 100);
      msg_load = 1'b0;
      chk("msg_exit_timeout", {31'd0, e_busy}, 32'd0);
      chk("msg_frames_seen", nft, 2);
      chk("msg_exit_busy", {31'd0, msg_busy}, 32'd0);
      chk("msg_exit_an", {28'd0, an}, 32'he);
      chk("msg_exit_bcd", {27'd0, bcd}, 32'd1);
      repeat (2 * SD) step();

      // Load with zero frames while idle is ignored.
      msg_load = 1'b1; msg_frames = 8'd0; msg_code = 20'hFFFFF;
      step();
      msg_load = 1'b0;
      chk("zero_frames_busy", {31'd0, msg_busy}, 32'd0);
      repeat (4 * SD) step();

      // Reset in the middle of a message.
      msg_load = 1'b1; msg_code = {5'h10, 5'h11, 5'h11, 5'h0f}; msg_frames = 8'd3;
      step();
      msg_load = 1'b0;
      repeat (9) step();
      chk("pre_rst_busy", {31'd0, msg_busy}, 32'd1);
      do_reset();
      chk("midrst_an", {28'd0, an}, 32'hf);
      chk("midrst_bcd", {27'd0, bcd}, 32'h0f);
      chk("midrst_busy", {31'd0, msg_busy}, 32'd0);
      repeat (SD - 1) step();
      chk("midrst_wait_an", {28'd0, an}, 32'hf);
      step();
      chk("midrst_restart_an", {28'd0, an}, 32'he);
      chk("midrst_restart_bcd", {27'd0, bcd}, 32'd1);

      // Random traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 15) == 0) begin
            for (int f = 0; f < 4; f++)
               digits_i[f*5 +: 5] = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom);
            blank_lz   = 1'($urandom);
            blink_mask = 4'($urandom);
         end
         msg_load   = ($urandom_range(0, 49) == 0);
         msg_code   = 20'($urandom);
         msg_frames = 8'($urandom_range(0, 3));
         reset      = ($urandom_range(0, 399) == 0);
         step();
      end
      reset = 1'b0; msg_load = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
